// File: rtl/lsu_mem_if.sv
// Load/store unit: accepts one CPU memory request, drives the data memory for
// one cycle, then returns a registered, extended response with a fault flag.
module lsu_mem_if #(
    parameter int unsigned MEM_SIZE         = 131072,
    parameter logic [31:0] RESERVED_TOP     = 32'h0000_0100,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_fault_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_wr_data_o,
    output logic [3:0]  mem_byte_en_o,
    input  logic [31:0] mem_rd_data_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_next;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        fault_q;

    logic        funct3_ok;
    logic        misaligned;
    logic [32:0] last_byte;
    logic [1:0]  size_m1;
    logic        req_fault;
    logic [31:0] load_data;

    // Fault is decided at acceptance; last byte uses 33 bits so wrap-around faults.
    always_comb begin
        case (req_funct3_i)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = !req_we_i;
            default:                funct3_ok = 1'b0;
        endcase
        case (req_funct3_i[1:0])
            2'b00:   size_m1 = 2'd0;
            2'b01:   size_m1 = 2'd1;
            default: size_m1 = 2'd3;
        endcase
        last_byte  = {1'b0, req_addr_i} + {31'd0, size_m1};
        misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                     ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
        req_fault  = !funct3_ok
                  || (last_byte >= 33'(MEM_SIZE))
                  || (req_we_i && (req_addr_i < RESERVED_TOP))
                  || (!ALLOW_MISALIGNED && misaligned);
    end

    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{24{mem_rd_data_i[7]}}, mem_rd_data_i[7:0]};
            3'b001:  load_data = {{16{mem_rd_data_i[15]}}, mem_rd_data_i[15:0]};
            3'b010:  load_data = mem_rd_data_i;
            3'b100:  load_data = {24'd0, mem_rd_data_i[7:0]};
            3'b101:  load_data = {16'd0, mem_rd_data_i[15:0]};
            default: load_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q         <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            fault_q      <= 1'b0;
            resp_rdata_o <= '0;
            resp_fault_o <= 1'b0;
        end else begin
            if (state == IDLE && req_valid_i) begin
                we_q     <= req_we_i;
                funct3_q <= req_funct3_i;
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
                fault_q  <= req_fault;
            end
            if (state == ACCESS) begin
                resp_rdata_o <= (we_q || fault_q) ? '0 : load_data;
                resp_fault_o <= fault_q;
            end
        end
    end

    always_comb begin
        state_next    = state;
        req_ready_o   = 1'b0;
        resp_valid_o  = 1'b0;
        mem_addr_o    = '0;
        mem_wr_en_o   = 1'b0;
        mem_wr_data_o = '0;
        mem_byte_en_o = '0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_next = ACCESS;
            end
            ACCESS: begin
                mem_addr_o    = addr_q;
                mem_wr_data_o = wdata_q;
                mem_wr_en_o   = we_q && !fault_q && !rst;
                if (!fault_q) begin
                    case (funct3_q[1:0])
                        2'b00:   mem_byte_en_o = 4'b0001;
                        2'b01:   mem_byte_en_o = 4'b0011;
                        2'b10:   mem_byte_en_o = 4'b1111;
                        default: mem_byte_en_o = 4'b0000;
                    endcase
                end
                state_next = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: directed plan plus random requests against a byte-array
// memory reference; the DUT talks to a separate behavioural data memory.
module tb_lsu_mem_if;

    localparam int unsigned MEM_SIZE = 131072;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rd_data;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_pulses = 0;
    int exp_writes = 0;

    logic [7:0] mem     [MEM_SIZE];
    logic [7:0] ref_mem [MEM_SIZE];

    always #5 clk = ~clk;

    lsu_mem_if #(
        .MEM_SIZE(MEM_SIZE),
        .RESERVED_TOP(32'h0000_0100),
        .ALLOW_MISALIGNED(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_we_i(req_we),
        .req_funct3_i(req_funct3),
        .req_addr_i(req_addr),
        .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata),
        .resp_fault_o(resp_fault),
        .mem_addr_o(mem_addr),
        .mem_wr_en_o(mem_wr_en),
        .mem_wr_data_o(mem_wr_data),
        .mem_byte_en_o(mem_byte_en),
        .mem_rd_data_i(mem_rd_data)
    );

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (a < MEM_SIZE) return mem[a];
        return 8'h00;
    endfunction

    // Data memory: combinational read zero-extended to the access size, synchronous write.
    always_comb begin
        mem_rd_data = '0;
        for (int i = 0; i < 4; i++)
            if (mem_byte_en[i]) mem_rd_data[8*i +: 8] = rd_byte(mem_addr + 32'(i));
    end

    always @(posedge clk) begin
        if (mem_wr_en) begin
            wr_pulses++;
            for (int i = 0; i < 4; i++)
                if (mem_byte_en[i] && (mem_addr + 32'(i)) < MEM_SIZE)
                    mem[mem_addr + 32'(i)] <= mem_wr_data[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference: fault, byte enables and load value from the architectural rules.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic fault,
                         output logic [31:0] rdata, output logic [3:0] be);
        int size;
        bit valid;
        longint last;
        logic [31:0] v;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        valid = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        last  = longint'({32'd0, addr}) + size - 1;
        fault = !valid || last >= MEM_SIZE || (we && addr < 32'h100);
        be    = fault ? 4'b0000 : (size == 1) ? 4'b0001 : (size == 2) ? 4'b0011 : 4'b1111;
        rdata = '0;
        if (!fault && we) begin
            for (int i = 0; i < size; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
            exp_writes++;
        end else if (!fault) begin
            v = '0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[addr + 32'(i)];
            case (f3)
                3'd0: rdata = 32'($signed(v[7:0]));
                3'd1: rdata = 32'($signed(v[15:0]));
                3'd2: rdata = v;
                3'd4: rdata = {24'd0, v[7:0]};
                default: rdata = {16'd0, v[15:0]};
            endcase
        end
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        logic efault;
        logic [31:0] erd;
        logic [3:0] ebe;
        model(we, f3, addr, wdata, efault, erd, ebe);
        @(negedge clk);
        check("idle_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        check("acc_ready", {31'd0, req_ready}, 32'd0);
        check("acc_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("acc_addr", mem_addr, addr);
        check("acc_byte_en", {28'd0, mem_byte_en}, {28'd0, ebe});
        check("acc_wr_en", {31'd0, mem_wr_en}, {31'd0, we && !efault});
        check("acc_wr_data", mem_wr_data, wdata);
        @(negedge clk);
        check("resp_valid", {31'd0, resp_valid}, 32'd1);
        check("resp_rdata", resp_rdata, erd);
        check("resp_fault", {31'd0, resp_fault}, {31'd0, efault});
        check("resp_byte_en", {28'd0, mem_byte_en}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ef;
        logic [31:0] erd, erd2;
        logic [3:0]  ebe;
        logic [31:0] a, w;
        logic        we;
        logic [2:0]  f3;
        int          n_diff;

        for (int i = 0; i < MEM_SIZE; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_fault", {31'd0, resp_fault}, 32'd0);
        check("rst_byte_en", {28'd0, mem_byte_en}, 32'd0);
        check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_wr_data", mem_wr_data, 32'd0);
        rst = 1'b0;

        run_req(1'b1, 3'b010, 32'h0001_0004, 32'hA1B2_C3D4);
        run_req(1'b0, 3'b000, 32'h0001_0006, 32'h0);
        check("lb_const", resp_rdata, 32'hFFFF_FFB2);
        run_req(1'b0, 3'b100, 32'h0001_0006, 32'h0);
        check("lbu_const", resp_rdata, 32'h0000_00B2);
        run_req(1'b0, 3'b001, 32'h0001_0006, 32'h0);
        check("lh_const", resp_rdata, 32'hFFFF_A1B2);
        run_req(1'b0, 3'b010, 32'h0001_0004, 32'h0);
        check("lw_const", resp_rdata, 32'hA1B2_C3D4);
        run_req(1'b1, 3'b000, 32'h0000_0080, 32'h55);
        run_req(1'b0, 3'b010, 32'h0001_FFFE, 32'h0);
        run_req(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
        run_req(1'b0, 3'b011, 32'h0001_0000, 32'h0);
        run_req(1'b1, 3'b100, 32'h0001_0000, 32'h1234_5678);
        run_req(1'b0, 3'b101, 32'h0001_FFFE, 32'h0);
        run_req(1'b1, 3'b000, 32'h0000_0100, 32'h77);

        // Backpressure: response held while the next request waits.
        model(1'b0, 3'b010, 32'h0001_0004, 32'h0, ef, erd, ebe);
        model(1'b0, 3'b100, 32'h0001_0004, 32'h0, ef, erd2, ebe);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0001_0004;
        @(negedge clk);
        req_funct3 = 3'b100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, erd);
            check("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("release_ready", {31'd0, req_ready}, 32'd1);
        check("release_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("next_byte_en", {28'd0, mem_byte_en}, 32'h1);
        @(negedge clk);
        check("next_rdata", resp_rdata, erd2);

        // Reset during the ACCESS cycle of a store: no write, no response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0001_0010; req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_acc_wr_en", {31'd0, mem_wr_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_acc_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_acc_ready", {31'd0, req_ready}, 32'd1);
        check("rst_acc_word", {mem[32'h10013], mem[32'h10012], mem[32'h10011], mem[32'h10010]}, 32'd0);

        for (int n = 0; n < 120; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0, 1: a = 32'h0001_0000 + $urandom_range(0, 31);
                2:    a = $urandom_range(0, 32'h1FF);
                3:    a = MEM_SIZE - $urandom_range(1, 6);
                4:    a = $urandom;
                default: a = 32'hFFFF_FFFF - $urandom_range(0, 4);
            endcase
            w = $urandom;
            run_req(we, f3, a, w);
        end

        @(negedge clk);
        check("write_count", 32'(wr_pulses), 32'(exp_writes));
        n_diff = 0;
        for (int i = 0; i < MEM_SIZE; i++) if (mem[i] !== ref_mem[i]) n_diff++;
        check("mem_image", 32'(n_diff), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
